time_budget_accumulator: RTL and testbench

//   Parametrised successor to the game's fixed four-module time accumulator.
//   On a start pulse, sums per-module time allowances for every enabled puzzle module,
//   one module per clock, with saturation at a cap.

---
 rtl/time_budget_accumulator.sv | 165 ++++++++++++++++
 tb/tb_time_budget_accumulator.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/time_budget_accumulator.sv
// Sums per-slot time allowances of enabled puzzle modules, one slot per clock, saturating at MAX_TIME.
// Optional difficulty scaling stage enabled by defining TIME_BUDGET_DIFFICULTY_EN.
module time_budget_accumulator #(
    parameter int NUM_MODULES = 4,
    parameter int TIME_W      = 11,
    parameter int MOD_TIME_W  = 8,
    parameter int MAX_TIME    = 1999
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              start,
    input  logic [NUM_MODULES-1:0]            enable,
    input  logic [NUM_MODULES*MOD_TIME_W-1:0] mod_time,
`ifdef TIME_BUDGET_DIFFICULTY_EN
    input  logic [1:0]                        difficulty,
`endif
    output logic [TIME_W-1:0]                 time_count,
    output logic                              busy,
    output logic                              accum_done,
    output logic                              saturated
);

    localparam int                IDX_W    = (NUM_MODULES > 1) ? $clog2(NUM_MODULES) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_MODULES - 1);
    localparam logic [TIME_W:0]   MAX_SUM  = (TIME_W + 1)'(MAX_TIME);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_SCALE,
        ST_DONE
    } state_t;

    state_t                            r_state;
    state_t                            w_state_next;
    logic [NUM_MODULES-1:0]            r_enable_q;
    logic [NUM_MODULES*MOD_TIME_W-1:0] r_time_q;
    logic [TIME_W:0]                   r_sum;
    logic [IDX_W-1:0]                  r_idx;
    logic [TIME_W-1:0]                 r_time_count;
    logic                              r_busy;
    logic                              r_done;
    logic                              r_sat;

    logic                              w_accept;
    logic                              w_last;
    logic                              w_slot_en;
    logic [MOD_TIME_W-1:0]             w_slot_time;
    logic [TIME_W:0]                   w_add;
    logic                              w_clamp;
    logic [TIME_W:0]                   w_sum_next;

    assign w_accept    = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_last      = (r_idx == LAST_IDX);
    assign w_slot_en   = r_enable_q[r_idx];
    assign w_slot_time = r_time_q[r_idx*MOD_TIME_W +: MOD_TIME_W];
    // The sum is one bit wider than the result, so sum + slot never wraps before the clamp.
    assign w_add       = w_slot_en ? (r_sum + (TIME_W + 1)'(w_slot_time)) : r_sum;
    assign w_clamp     = (w_add > MAX_SUM);
    assign w_sum_next  = w_clamp ? MAX_SUM : w_add;

`ifdef TIME_BUDGET_DIFFICULTY_EN
    logic [1:0]        r_diff;
    logic [TIME_W-1:0] w_base;
    logic [TIME_W-1:0] w_scaled;

    assign w_base = r_sum[TIME_W-1:0];

    always_comb begin
        case (r_diff)
            2'd1:    w_scaled = w_base - (w_base >> 2);
            2'd2:    w_scaled = w_base >> 1;
            2'd3:    w_scaled = w_base >> 2;
            default: w_scaled = w_base;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_diff <= 2'd0;
        end else if (w_accept) begin
            r_diff <= difficulty;
        end
    end
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_state_next = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (w_last) begin
`ifdef TIME_BUDGET_DIFFICULTY_EN
                    w_state_next = ST_SCALE;
`else
                    w_state_next = ST_DONE;
`endif
                end
            end
            ST_SCALE: w_state_next = ST_DONE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_enable_q   <= '0;
            r_time_q     <= '0;
            r_sum        <= '0;
            r_idx        <= '0;
            r_time_count <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_sat        <= 1'b0;
        end else if (w_accept) begin
            r_enable_q <= enable;
            r_time_q   <= mod_time;
            r_sum      <= '0;
            r_idx      <= '0;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_sat      <= 1'b0;
        end else if (r_state == ST_ACCUM) begin
            r_sum <= w_sum_next;
            r_idx <= r_idx + 1'b1;
            if (w_clamp) begin
                r_sat <= 1'b1;
            end
`ifndef TIME_BUDGET_DIFFICULTY_EN
            if (w_last) begin
                r_time_count <= w_sum_next[TIME_W-1:0];
                r_done       <= 1'b1;
                r_busy       <= 1'b0;
            end
`endif
        end
`ifdef TIME_BUDGET_DIFFICULTY_EN
        else if (r_state == ST_SCALE) begin
            r_time_count <= w_scaled;
            r_done       <= 1'b1;
            r_busy       <= 1'b0;
        end
`endif
    end

    assign time_count = r_time_count;
    assign busy       = r_busy;
    assign accum_done = r_done;
    assign saturated  = r_sat;

endmodule

// File: tb/tb_time_budget_accumulator.sv
// Self-checking bench for time_budget_accumulator: directed cases, randomized traffic against a
// transaction-level model, and a 16-slot instance for the saturation boundary.
module tb_time_budget_accumulator;

    localparam int N      = 4;
    localparam int TW     = 11;
    localparam int MW     = 8;
    localparam int TB_MAX = 700;
    localparam int N16    = 16;
`ifdef TIME_BUDGET_DIFFICULTY_EN
    localparam int LAT   = N + 1;
    localparam int LAT16 = N16 + 1;
`else
    localparam int LAT   = N;
    localparam int LAT16 = N16;
`endif

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            start = 1'b0;
    logic [N-1:0]    enable = '0;
    logic [N*MW-1:0] mod_time = '0;
    logic [1:0]      difficulty = 2'd0;
    logic [TW-1:0]   time_count;
    logic            busy, accum_done, saturated;

    logic              start16 = 1'b0;
    logic [N16-1:0]    enable16 = '0;
    logic [N16*MW-1:0] mod_time16 = '0;
    logic [TW-1:0]     time_count16;
    logic              busy16, accum_done16, saturated16;

    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    time_budget_accumulator #(
        .NUM_MODULES(N), .TIME_W(TW), .MOD_TIME_W(MW), .MAX_TIME(TB_MAX)
    ) u_dut (
        .clock(clock), .reset(reset), .start(start), .enable(enable), .mod_time(mod_time),
`ifdef TIME_BUDGET_DIFFICULTY_EN
        .difficulty(difficulty),
`endif
        .time_count(time_count), .busy(busy), .accum_done(accum_done), .saturated(saturated)
    );

    time_budget_accumulator #(
        .NUM_MODULES(N16), .TIME_W(TW), .MOD_TIME_W(MW), .MAX_TIME(1999)
    ) u_dut16 (
        .clock(clock), .reset(reset), .start(start16), .enable(enable16), .mod_time(mod_time16),
`ifdef TIME_BUDGET_DIFFICULTY_EN
        .difficulty(2'd0),
`endif
        .time_count(time_count16), .busy(busy16), .accum_done(accum_done16), .saturated(saturated16)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: on an accepted start the final result and the edge at which
    // the clamp first happens are computed outright; a countdown only times their appearance.
    int            m_left   = 0;
    int            m_sat_at = -1;
    logic          m_busy   = 1'b0;
    logic          m_done   = 1'b0;
    logic          m_sat    = 1'b0;
    logic [TW-1:0] m_count  = '0;
    logic [TW-1:0] m_pend   = '0;

    task automatic model_run(input logic [N-1:0] en, input logic [N*MW-1:0] tm, input logic [1:0] d);
        int s;
        s = 0;
        m_sat_at = -1;
        for (int i = 0; i < N; i++) begin
            if (en[i]) begin
                s = s + int'(tm[i*MW +: MW]);
                if (s > TB_MAX) begin
                    s = TB_MAX;
                    if (m_sat_at < 0) m_sat_at = i + 1;
                end
            end
        end
`ifdef TIME_BUDGET_DIFFICULTY_EN
        case (d)
            2'd1:    s = s - s / 4;
            2'd2:    s = s / 2;
            2'd3:    s = s / 4;
            default: s = s;
        endcase
`else
        if (d > 2'd3) s = 0;
`endif
        m_pend = TW'(s);
    endtask

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_left  = 0;
            m_busy  = 1'b0;
            m_done  = 1'b0;
            m_sat   = 1'b0;
            m_count = '0;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
            if (m_sat_at >= 0 && (LAT - m_left) >= m_sat_at) m_sat = 1'b1;
            if (m_left == 0) begin
                m_busy  = 1'b0;
                m_done  = 1'b1;
                m_count = m_pend;
            end
        end else if (start) begin
            model_run(enable, mod_time, difficulty);
            m_left = LAT;
            m_busy = 1'b1;
            m_done = 1'b0;
            m_sat  = 1'b0;
        end
    end

    always @(negedge clock) begin
        if (reset === 1'b1) begin
            check("cmp_time_count", 32'(time_count), 32'(m_count));
            check("cmp_busy",       32'(busy),       32'(m_busy));
            check("cmp_accum_done", 32'(accum_done), 32'(m_done));
            check("cmp_saturated",  32'(saturated),  32'(m_sat));
        end
    end

    // Pulse start for one cycle and count edges until accum_done, bounded.
    task automatic run_wait(output int k);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("start_clears_done", 32'(accum_done), 32'd0);
        check("start_sets_busy",   32'(busy),       32'd1);
        k = 0;
        while (!accum_done && k < 50) begin
            @(negedge clock);
            k++;
        end
    endtask

    function automatic logic [N*MW-1:0] all_times(input logic [MW-1:0] t);
        logic [N*MW-1:0] v;
        for (int i = 0; i < N; i++) v[i*MW +: MW] = t;
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int k;

        repeat (3) @(negedge clock);
        check("reset_time_count", 32'(time_count), 32'd0);
        check("reset_busy",       32'(busy),       32'd0);
        check("reset_done",       32'(accum_done), 32'd0);
        check("reset_sat",        32'(saturated),  32'd0);
        reset = 1'b1;
        @(negedge clock);

        enable = 4'b1111; mod_time = all_times(8'd100);
        run_wait(k);
        check("lat_all100", 32'(k), 32'(LAT));
        check("val_all100", 32'(time_count), 32'd400);
        check("sat_all100", 32'(saturated), 32'd0);

        enable = 4'b0101; mod_time = {8'd50, 8'd60, 8'd70, 8'd80};
        run_wait(k);
        check("val_0101", 32'(time_count), 32'd140);

        enable = 4'b0000;
        run_wait(k);
        check("lat_none", 32'(k), 32'(LAT));
        check("val_none", 32'(time_count), 32'd0);
        check("sat_none", 32'(saturated), 32'd0);

        enable = 4'b1111; mod_time = all_times(8'd255);
        run_wait(k);
        check("val_clamp", 32'(time_count), 32'd700);
        check("sat_clamp", 32'(saturated), 32'd1);

        mod_time = all_times(8'd175);
        run_wait(k);
        check("val_exact_cap", 32'(time_count), 32'd700);
        check("sat_exact_cap", 32'(saturated), 32'd0);

        // Inputs and start change mid-run; the snapshot taken at the accepted start must win.
        enable = 4'b1111; mod_time = all_times(8'd100);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0; enable = 4'b0001; mod_time = all_times(8'd200);
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        k = 2;
        while (!accum_done && k < 50) begin
            @(negedge clock);
            k++;
        end
        check("snap_lat", 32'(k), 32'(LAT));
        check("snap_val", 32'(time_count), 32'd400);

        // Restart straight from the DONE cycle.
        enable = 4'b0011; mod_time = all_times(8'd10);
        run_wait(k);
        check("restart_lat", 32'(k), 32'(LAT));
        check("restart_val", 32'(time_count), 32'd20);

        // Reset two cycles into a run.
        enable = 4'b1111; mod_time = all_times(8'd255);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("midrst_time_count", 32'(time_count), 32'd0);
        check("midrst_busy",       32'(busy),       32'd0);
        check("midrst_done",       32'(accum_done), 32'd0);
        check("midrst_sat",        32'(saturated),  32'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        mod_time = all_times(8'd100);
        run_wait(k);
        check("post_rst_lat", 32'(k), 32'(LAT));
        check("post_rst_val", 32'(time_count), 32'd400);

`ifdef TIME_BUDGET_DIFFICULTY_EN
        difficulty = 2'd1;
        run_wait(k);
        check("diff1_val", 32'(time_count), 32'd300);
        difficulty = 2'd3;
        run_wait(k);
        check("diff3_val", 32'(time_count), 32'd100);
        difficulty = 2'd0;
`endif

        // 16-slot instance: eight 255s exceed 1999, so the clamp lands on the eighth edge.
        enable16 = '1;
        for (int i = 0; i < N16; i++) mod_time16[i*MW +: MW] = 8'd255;
        start16 = 1'b1;
        @(negedge clock);
        start16 = 1'b0;
        check("n16_busy", 32'(busy16), 32'd1);
        k = 0;
        while (!accum_done16 && k < 60) begin
            @(negedge clock);
            k++;
            if (k == 7) check("n16_sat_before", 32'(saturated16), 32'd0);
            if (k == 8) check("n16_sat_at",     32'(saturated16), 32'd1);
        end
        check("n16_lat", 32'(k), 32'(LAT16));
        check("n16_val", 32'(time_count16), 32'd1999);
        check("n16_sat", 32'(saturated16), 32'd1);

        // Randomized traffic: start pulses land in every state and inputs churn mid-run.
        for (int c = 0; c < 3000; c++) begin
            start = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 2) == 0) begin
                enable = N'($urandom);
                for (int i = 0; i < N; i++) mod_time[i*MW +: MW] = MW'($urandom_range(0, 255));
                difficulty = 2'($urandom);
            end
            @(negedge clock);
        end
        start = 1'b0;
        repeat (LAT + 2) @(negedge clock);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
